mem_arbiter: RTL

Two-port arbiter and sequencer for the single DPI-backed physical memory port. It sits between the instruction-fetch unit (read-only) and the load/store unit (read/write) on one side and the `MEM` wrapper on the other. It accepts one transaction at a time with round-robin fairness, models a configurable access latency, and returns data or a write acknowledge to the owning requester. It guarantees exactly one `mem_ce` pulse per transaction, so each access triggers exactly one `pmem_read`/`pmem_write` call.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_rr_arb.sv | 11 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port physical memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int LAT_DEF    = 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {IFU = 1'b0, LSU = 1'b1} req_id_e;
endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin picker: the requester not served last wins a tie.
module mem_rr_arb
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output logic [1:0] gnt
);
  assign gnt[IFU] = req[IFU] & (~req[LSU] | (last == LSU));
  assign gnt[LSU] = req[LSU] & (~req[IFU] | (last == IFU));
endmodule

// File: rtl/mem_arbiter.sv
// Serialises IFU and LSU accesses onto one memory port with a fixed access
// latency, one mem_ce pulse per transaction and a one-cycle response strobe.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_we,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state;
  logic [CNT_W-1:0]  cnt;
  req_id_e           last_q, owner_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        req, gnt;
  logic              acc_ifu, acc_lsu;

  assign req = {lsu_req_valid, ifu_req_valid};

  mem_rr_arb u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  // Readies are gated by rst so nothing can look accepted during reset.
  assign ifu_req_ready = (state == IDLE) & ~rst & gnt[IFU];
  assign lsu_req_ready = (state == IDLE) & ~rst & gnt[LSU];
  assign acc_ifu       = ifu_req_valid & ifu_req_ready;
  assign acc_lsu       = lsu_req_valid & lsu_req_ready;

  assign ifu_rdata = rdata_q;
  assign lsu_rdata = rdata_q;

  // mem_ce/mem_we are raised one cycle ahead of the count reaching zero so
  // they come out of a flop yet line up with the capture cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      last_q         <= IFU;
      owner_q        <= IFU;
      we_q           <= 1'b0;
      rdata_q        <= '0;
      mem_ce         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_ifu || acc_lsu) begin
            owner_q   <= acc_lsu ? LSU : IFU;
            mem_addr  <= acc_lsu ? lsu_addr : ifu_addr;
            mem_wdata <= acc_lsu ? lsu_wdata : '0;
            mem_wmask <= acc_lsu ? lsu_wmask : 8'h00;
            we_q      <= acc_lsu & lsu_we;
            cnt       <= CNT_W'(LAT - 1);
            mem_ce    <= (LAT == 1);
            mem_we    <= (LAT == 1) & acc_lsu & lsu_we;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rdata_q        <= we_q ? '0 : mem_rdata;
            mem_ce         <= 1'b0;
            mem_we         <= 1'b0;
            ifu_resp_valid <= (owner_q == IFU);
            lsu_resp_valid <= (owner_q == LSU);
            state          <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              mem_ce <= 1'b1;
              mem_we <= we_q;
            end
          end
        end
        RESP: begin
          ifu_resp_valid <= 1'b0;
          lsu_resp_valid <= 1'b0;
          last_q         <= owner_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
